muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO unit for the MIPS subset: sequences MULT, MULTU, DIV and DIVU over 32 iterations and owns the HI and LO registers.
- Sits beside the ALU in the execute stage and is started by the main control unit.
- Drives a stall request so that MFHI/MFLO and new HI/LO operations wait while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand or dividend.
- rt_val  in  WIDTH  multiplier or divisor.
- mthi  in  1  write wdata to HI (MTHI).
- mtlo  in  1  write wdata to LO (MTLO).
- wdata  in  WIDTH  data for MTHI/MTLO.
- rd_hilo  in  1  current instruction reads HI/LO (MFHI/MFLO).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse in the cycle HI/LO take a new result.
- stall  out  1  busy & (rd_hilo | start | mthi | mtlo).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation aborts it with no HI/LO update.
- States:
  - IDLE -> RUN on start.
  - RUN -> FIX when counter==WIDTH-1.
  - FIX -> IDLE unconditionally.
- IDLE, start=1:
  - Latch op.
  - For signed ops, latch |rs_val| and |rt_val| plus sign flags.
  - Clear the accumulator; counter=0.
  - start has priority over mthi/mtlo in the same cycle; those writes are dropped.
- IDLE, start=0: mthi writes hi; mtlo writes lo; both may write in the same cycle.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first. The 2*WIDTH product accumulates in {acc_hi, acc_lo}.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits so the trial subtract keeps its borrow.
- Counter increments each RUN cycle, giving exactly WIDTH RUN cycles.
- FIX: apply sign, write hi/lo, done=1 for this cycle only.
  - MULT: negate the 64-bit product if sign_rs^sign_rt.
  - DIV: negate the quotient if sign_rs^sign_rt; the remainder takes the dividend's sign.
  - Then hi=upper/remainder, lo=lower/quotient.
- Latency: start accepted at edge E0. busy is high for the WIDTH+1 cycles after E0. New hi/lo are visible after edge E0+WIDTH+1, when done is high.
- Divide by zero (rt_val=0), no trap:
  - DIVU: lo=0xFFFFFFFF, hi=rs_val.
  - DIV: lo=0xFFFFFFFF, hi=rs_val, with no sign fixup applied.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- While busy:
  - start, mthi and mtlo are ignored.
  - stall is asserted combinationally; upstream holds the instruction until busy falls.
  - rd_hilo while busy asserts stall; hi/lo still show the old values.
- The cycle after FIX is IDLE, so a back-to-back start is accepted there.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state typedef {IDLE, RUN, FIX}.
  - WIDTH default constant.
- Sub-module muldiv_sign_fix: combinational. Handles absolute value at start and the conditional two's-complement negate of the product, quotient and remainder at FIX. It is instantiated once for operand conditioning and once for result fixup.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high for exactly 33 cycles.
- MULT -7 x 3, DIV -7 / 2 -> MULT: hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. Then DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- Hazards while busy:
  - rd_hilo=1 at cycle 5 of RUN -> stall=1, hi/lo unchanged.
  - mthi pulse during RUN -> ignored.
  - start during RUN -> ignored, with no restart.
- Reset and simultaneous requests:
  - reset at RUN cycle 10 -> next cycle state IDLE, hi=lo=0, no done pulse.
  - In IDLE, start+mthi together -> operation runs, hi not written from wdata.
- MTHI/MTLO in IDLE with wdata=0x1234 -> hi=0x1234 next cycle.
  - Then mthi and mtlo together with 0xABCD -> hi=lo=0xABCD.
  - Then back-to-back MULTU ops, with the second start in the cycle after done -> both results correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef logic [1:0] op_t;
  localparam op_t OP_MULT  = 2'b00;
  localparam op_t OP_MULTU = 2'b01;
  localparam op_t OP_DIV   = 2'b10;
  localparam op_t OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  // Signed variants take absolute values up front and fix signs at the end.
  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_t op);
    return !((op == OP_MULT) || (op == OP_MULTU));
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of two words, either independently
// or joined as one double-width value (i_a is the upper half).
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_neg_a,
  input  logic             i_neg_b,
  input  logic             i_join,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  logic [2*WIDTH-1:0] w_neg_wide;
  logic [WIDTH-1:0]   w_neg_a;
  logic [WIDTH-1:0]   w_neg_b;

  assign w_neg_wide = (2*WIDTH)'(0) - {i_a, i_b};
  assign w_neg_a    = WIDTH'(0) - i_a;
  assign w_neg_b    = WIDTH'(0) - i_b;

  // In joined mode i_neg_b selects the negate of the whole double word.
  always_comb begin
    o_a = i_a;
    o_b = i_b;
    if (i_join) begin
      if (i_neg_b) begin
        {o_a, o_b} = w_neg_wide;
      end
    end else begin
      if (i_neg_a) o_a = w_neg_a;
      if (i_neg_b) o_b = w_neg_b;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls HI/LO users while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [CNT_W-1:0] r_cnt;
  op_t              r_op;
  logic             r_sign_rs;
  logic             r_sign_rt;
  logic             r_div0;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_op_signed;
  logic             w_run_div;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_rs;
  logic [WIDTH-1:0] w_abs_rt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_fix_neg_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_op_signed = op_is_signed(op);
  assign w_run_div   = op_is_div(r_op);
  assign w_last      = (r_cnt == CNT_W'(WIDTH-1));

  // Operand conditioning: absolute values for signed operations.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .i_a     (rs_val),
    .i_b     (rt_val),
    .i_neg_a (w_op_signed & rs_val[WIDTH-1]),
    .i_neg_b (w_op_signed & rt_val[WIDTH-1]),
    .i_join  (1'b0),
    .o_a     (w_abs_rs),
    .o_b     (w_abs_rt)
  );

  // Shift-add step: add multiplicand when the current multiplier bit is set.
  assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : (WIDTH+1)'(0));

  // Restoring-divide step: bring in the next dividend bit and trial-subtract.
  assign w_shift  = {r_rem, r_acc_lo[WIDTH-1]};
  assign w_trial  = w_shift - {2'b00, r_opb};
  assign w_borrow = w_trial[WIDTH+1];

  // Divide by zero keeps quotient all ones; remainder sign restores rs_val.
  assign w_res_hi     = w_run_div ? r_rem[WIDTH-1:0] : r_acc_hi;
  assign w_fix_neg_lo = (r_sign_rs ^ r_sign_rt) & ~(w_run_div & r_div0);

  // Result fixup: joined 2W negate for products, split negate for div.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_a     (w_res_hi),
    .i_b     (r_acc_lo),
    .i_neg_a (r_sign_rs),
    .i_neg_b (w_fix_neg_lo),
    .i_join  (~w_run_div),
    .o_a     (w_fix_hi),
    .o_b     (w_fix_lo)
  );

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (r_state == ST_FIX);
  end

  // State register with busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Operand latch and per-iteration multiply/divide datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op      <= OP_MULT;
      r_sign_rs <= 1'b0;
      r_sign_rt <= 1'b0;
      r_div0    <= 1'b0;
      r_opb     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_rem     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_sign_rs <= w_op_signed & rs_val[WIDTH-1];
            r_sign_rt <= w_op_signed & rt_val[WIDTH-1];
            r_div0    <= (rt_val == '0);
            r_opb     <= w_abs_rt;
            r_acc_lo  <= w_abs_rs;
            r_acc_hi  <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_run_div) begin
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_borrow};
            r_rem    <= w_borrow ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
          end else begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only in IDLE without a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if ((r_state == ST_IDLE) && !start) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = r_busy;
  assign done  = r_done;
  assign stall = r_busy & (rd_hilo | start | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, hazard sequences, random ops.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        rd_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int k;
  int bcnt;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .rd_hilo (rd_hilo),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: HI/LO contents from MIPS arithmetic rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    logic [63:0] r;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'(sa * sb);
      end
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          ia = a;
          ib = b;
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    if (busy) bcnt++;
    @(negedge clock);
    k++;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 1;
    bcnt = 0;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && k < 60) tick();
  endtask

  task automatic run_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string name);
    issue(o, a, b);
    wait_done();
    chk({name, "_latency"}, 64'(k), 64'd34);
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int nd;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd0,         32'd100,      32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b10, 32'hFFFF_FFEC, 32'd0,         32'hFFFF_FFEC, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'd7,         32'd3,         32'd1,        32'd2};
    vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,        32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hilo = 1'b0;
    k = 0; bcnt = 0;
    repeat (2) @(negedge clock);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // MTHI alone, then MTHI+MTLO together
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clock);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_untouched", 64'(lo), 64'd0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'hABCD);
    chk("mthilo_lo", 64'(lo), 64'hABCD);

    // Hazards while busy: read stall, ignored mthi, ignored start
    issue(2'b01, 32'd5, 32'd6);
    while (k < 6) tick();
    rd_hilo = 1'b1;
    #1;
    chk("hz_rd_stall", 64'(stall), 64'd1);
    chk("hz_rd_hi_old", 64'(hi), 64'hABCD);
    chk("hz_rd_lo_old", 64'(lo), 64'hABCD);
    rd_hilo = 1'b0;
    #1;
    chk("hz_no_req_stall", 64'(stall), 64'd0);
    mthi = 1'b1; wdata = 32'hFFFF;
    #1;
    chk("hz_mthi_stall", 64'(stall), 64'd1);
    tick();
    mthi = 1'b0;
    chk("hz_mthi_ignored", 64'(hi), 64'hABCD);
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    #1;
    chk("hz_start_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    wait_done();
    chk("hz_latency", 64'(k), 64'd34);
    chk("hz_busy_cycles", 64'(bcnt), 64'd33);
    chk("hz_hi", 64'(hi), 64'd0);
    chk("hz_lo", 64'(lo), 64'd30);

    // Vector table; consecutive entries start in the done cycle
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo,
              $sformatf("vec%0d", i));
    end
    @(negedge clock);
    chk("done_single_pulse", 64'(done), 64'd0);

    // Reset in the middle of RUN
    issue(2'b01, 32'h0001_2345, 32'h0000_0678);
    while (k < 11) tick();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_hi_hold", 64'(hi), 64'd0);

    // start and mthi in the same IDLE cycle: start wins
    op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
    start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    k = 1; bcnt = 0;
    chk("st_mthi_dropped", 64'(hi), 64'd0);
    chk("st_mthi_busy", 64'(busy), 64'd1);
    wait_done();
    chk("st_mthi_latency", 64'(k), 64'd34);
    chk("st_mthi_hi", 64'(hi), 64'd1);
    chk("st_mthi_lo", 64'(lo), 64'hFFFF_FFFE);

    // Random back-to-back operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: rb = $urandom;
      endcase
      if (i % 7 == 3) ra = 32'h8000_0000;
      exp = model(ro, ra, rb);
      run_vec(ro, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
